// File: rtl/bus_select_decoder_5_32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bus_select_decoder_5_32                                         |
// | Purpose  : registered 5-to-32 one-hot bus-select decoder with hold, break- |
// |            before-make gap, illegal-code rejection and completion strobe.  |
// | Options  : BUS_DEC_QUEUE_EN adds a one-entry request queue.                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module bus_select_decoder_5_32 #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter logic [31:0] VALID_MASK  = 32'h06FF_FFFF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  code,
  input  logic        valid,
  output logic        ready,
  input  logic        flush,
  output logic [31:0] sel,
  output logic        busy,
  output logic        done,
  output logic        err
);

  generate
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
      $error("bus_select_decoder_5_32: HOLD_CYCLES must be in 1..255");
    end
  endgenerate

  localparam logic [7:0] C_HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_sel;
  logic        r_done;
  logic        r_err;

  logic        w_ready;
  logic        w_accept;
  logic        w_q_full;
  logic [4:0]  w_q_code;
  logic        w_disp_vld;
  logic [4:0]  w_disp_code;
  logic        w_disp_legal;

`ifdef BUS_DEC_QUEUE_EN
  logic        r_q_vld;
  logic [4:0]  r_q_code;

  assign w_ready  = ~r_q_vld;
  assign w_q_full = r_q_vld;
  assign w_q_code = r_q_code;

  // Only requests arriving during DRIVE are parked; IDLE and GAP dispatch directly.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q_vld  <= 1'b0;
      r_q_code <= 5'd0;
    end else if (r_state == S_GAP) begin
      r_q_vld  <= 1'b0;
    end else if (w_accept && (r_state == S_DRIVE)) begin
      r_q_vld  <= 1'b1;
      r_q_code <= code;
    end
  end
`else
  assign w_ready  = (r_state == S_IDLE);
  assign w_q_full = 1'b0;
  assign w_q_code = 5'd0;
`endif

  assign w_accept = valid && ready;

  // A new drive can start from IDLE (direct request) or from GAP (queued or direct).
  assign w_disp_vld   = ((r_state == S_IDLE) && w_accept) ||
                        ((r_state == S_GAP) && (w_q_full || w_accept));
  assign w_disp_code  = w_q_full ? w_q_code : code;
  assign w_disp_legal = VALID_MASK[w_disp_code];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_sel   <= 32'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE, S_GAP: begin
          r_state <= S_IDLE;
          r_sel   <= 32'd0;
          r_cnt   <= 8'd0;
          if (w_disp_vld) begin
            if (w_disp_legal) begin
              r_state <= S_DRIVE;
              r_sel   <= 32'd1 << w_disp_code;
              r_cnt   <= C_HOLD_LOAD;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end
        S_DRIVE: begin
          if (flush || (r_cnt == 8'd0)) begin
            r_state <= S_GAP;
            r_sel   <= 32'd0;
            r_cnt   <= 8'd0;
            r_done  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sel   <= 32'd0;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign ready = w_ready & ~clr;
  assign sel   = r_sel;
  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_select_decoder_5_32.sv
`default_nettype none
// Bench for bus_select_decoder_5_32: two instances (HOLD 1 and 4) driven in
// lockstep and compared each cycle against a per-instance request-level model.
module tb_bus_select_decoder_5_32;

  localparam int NI = 2;
  localparam logic [31:0] MASK = 32'h06FF_FFFF;
`ifdef BUS_DEC_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic        clk;
  logic        clr;
  logic [4:0]  code;
  logic        valid;
  logic        flush;
  logic [31:0] sel_o   [NI];
  logic        ready_o [NI];
  logic        busy_o  [NI];
  logic        done_o  [NI];
  logic        err_o   [NI];

  bus_select_decoder_5_32 #(.HOLD_CYCLES(1), .VALID_MASK(MASK)) dut0 (
    .clk(clk), .clr(clr), .code(code), .valid(valid), .ready(ready_o[0]),
    .flush(flush), .sel(sel_o[0]), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0])
  );

  bus_select_decoder_5_32 #(.HOLD_CYCLES(4), .VALID_MASK(MASK)) dut1 (
    .clk(clk), .clr(clr), .code(code), .valid(valid), .ready(ready_o[1]),
    .flush(flush), .sel(sel_o[1]), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: what each instance is currently showing, plus its pending request.
  int          hold   [NI];
  logic [31:0] m_sel  [NI];
  int          m_left [NI];
  bit          m_gap  [NI];
  bit          m_done [NI];
  bit          m_err  [NI];
  bit          m_qv   [NI];
  logic [4:0]  m_qc   [NI];

  function automatic bit m_ready(int i);
    if (QEN) return !m_qv[i];
    return (m_sel[i] == 32'd0) && !m_gap[i];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NI; i++) begin
      m_sel[i] = 32'd0; m_left[i] = 0; m_gap[i] = 0;
      m_done[i] = 0; m_err[i] = 0; m_qv[i] = 0; m_qc[i] = 5'd0;
    end
  endtask

  task automatic m_step(int i, bit v, logic [4:0] c, bit f);
    bit acc;
    bit have;
    logic [4:0] src;
    acc  = v && m_ready(i);
    have = 0;
    src  = c;
    m_done[i] = 0;
    m_err[i]  = 0;
    if (m_sel[i] != 32'd0) begin
      if (QEN && acc) begin m_qv[i] = 1; m_qc[i] = c; end
      if (f || m_left[i] == 0) begin
        m_sel[i] = 32'd0; m_gap[i] = 1; m_done[i] = 1;
      end else begin
        m_left[i] = m_left[i] - 1;
      end
    end else begin
      if (m_gap[i] && m_qv[i]) begin have = 1; src = m_qc[i]; m_qv[i] = 0; end
      else if (acc) have = 1;
      m_gap[i] = 0;
      if (have) begin
        if (MASK[src]) begin m_sel[i] = 32'd1 << src; m_left[i] = hold[i] - 1; end
        else m_err[i] = 1;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("sel[%0d]", i),   sel_o[i],   m_sel[i]);
      chk($sformatf("done[%0d]", i),  {31'd0, done_o[i]},  {31'd0, m_done[i]});
      chk($sformatf("err[%0d]", i),   {31'd0, err_o[i]},   {31'd0, m_err[i]});
      chk($sformatf("busy[%0d]", i),  {31'd0, busy_o[i]},
          {31'd0, (m_sel[i] != 32'd0) || m_gap[i]});
      chk($sformatf("ready[%0d]", i), {31'd0, ready_o[i]}, {31'd0, m_ready(i)});
      chk($sformatf("onehot0[%0d]", i), {31'd0, $onehot0(sel_o[i])}, 32'd1);
    end
  endtask

  // Called at a negedge: drive inputs, clock once, update model, check.
  task automatic cyc(bit v, logic [4:0] c, bit f);
    valid = v; code = c; flush = f;
    @(posedge clk);
    for (int i = 0; i < NI; i++) m_step(i, v, c, f);
    #1;
    chk_all();
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(0, 5'd0, 0);
  endtask

  initial begin
    hold[0] = 1;
    hold[1] = 4;
    m_reset();
    clr = 1'b1; valid = 1'b0; code = 5'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_sel",   sel_o[i], 32'd0);
      chk("rst_busy",  {31'd0, busy_o[i]},  32'd0);
      chk("rst_ready", {31'd0, ready_o[i]}, 32'd0);
      chk("rst_done",  {31'd0, done_o[i]},  32'd0);
      chk("rst_err",   {31'd0, err_o[i]},   32'd0);
    end
    clr = 1'b0;
    #1;
    chk_all();
    @(negedge clk);

    // Basic drive, code 4
    cyc(1, 5'd4, 0);
    chk("basic_sel", sel_o[0], 32'h0000_0010);
    chk("basic_busy", {31'd0, busy_o[0]}, 32'd1);
    cyc(0, 5'd0, 0);
    chk("basic_done", {31'd0, done_o[0]}, 32'd1);
    chk("basic_gap_sel", sel_o[0], 32'd0);
    idle(5);

    // Extreme legal codes
    cyc(1, 5'd0, 0);
    chk("code0_sel", sel_o[1], 32'h0000_0001);
    idle(6);
    cyc(1, 5'd26, 0);
    chk("code26_sel", sel_o[1], 32'h0400_0000);
    idle(6);

    // Illegal codes
    cyc(1, 5'd24, 0);
    chk("ill24_err", {31'd0, err_o[1]}, 32'd1);
    cyc(0, 5'd0, 0);
    cyc(1, 5'd31, 0);
    chk("ill31_err", {31'd0, err_o[0]}, 32'd1);
    idle(2);

    // Flush in the second drive cycle of the HOLD=4 instance
    cyc(1, 5'd7, 0);
    cyc(0, 5'd0, 0);
    chk("flush_pre_sel", sel_o[1], 32'h80);
    cyc(0, 5'd0, 1);
    chk("flush_done", {31'd0, done_o[1]}, 32'd1);
    chk("flush_sel", sel_o[1], 32'd0);
    idle(3);

    // Back-to-back with valid held high
    cyc(1, 5'd3, 0);
    for (int k = 0; k < 8; k++) cyc(1, 5'd9, 0);
    idle(8);

    // Asynchronous reset in the middle of a drive
    cyc(1, 5'd5, 0);
    cyc(0, 5'd0, 0);
    chk("prerst_sel", sel_o[1], 32'h20);
    #2 clr = 1'b1;
    #1;
    m_reset();
    for (int i = 0; i < NI; i++) begin
      chk("arst_sel",   sel_o[i], 32'd0);
      chk("arst_busy",  {31'd0, busy_o[i]},  32'd0);
      chk("arst_done",  {31'd0, done_o[i]},  32'd0);
      chk("arst_ready", {31'd0, ready_o[i]}, 32'd0);
    end
    @(posedge clk);
    #1;
    chk("arst_hold_done", {31'd0, done_o[1]}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk_all();
    chk("arst_ready_after", {31'd0, ready_o[1]}, 32'd1);
    @(negedge clk);

    // Randomized traffic
    for (int k = 0; k < 400; k++)
      cyc(($urandom % 3) != 0, 5'($urandom % 32), ($urandom % 8) == 0);
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_select_decoder_5_32.md
Name: bus_select_decoder_5_32

Overview:
- Registered 5-to-32 decoder that drives one-hot bus-select / register-enable lines from a 5-bit select code.
- Inverse of the bus-source encoder: the control unit hands it a code, and it asserts exactly one select line for a fixed number of cycles.
- Inserts one all-zero break-before-make cycle after each drive.
- Rejects codes that have no bus source, and reports completion with a one-cycle strobe.

Parameters:
- HOLD_CYCLES, 1: cycles each select line stays asserted. Legal range 1..255; 0 is an elaboration error.
- VALID_MASK, 32'h06FF_FFFF: bit n set means code n is a legal source. Codes 24 and 27..31 are reserved.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous active-high reset
- code  input  5  select code to decode
- valid  input  1  request strobe; qualifies code
- ready  output  1  decoder can accept a request this cycle
- flush  input  1  synchronous abort of the current drive
- sel  output  32  registered one-hot select lines; all-zero when not driving
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse in the break cycle after a drive
- err  output  1  one-cycle pulse after an illegal code is accepted

Behaviour:
- Reset: clk is the only clock. clr is asynchronous and active-high. While clr is high:
  - sel=0, busy=0, done=0, err=0, ready=0
  - state=IDLE, hold counter=0, queue empty
  - This takes effect immediately, including mid-drive; no done pulse is produced.
- Accept: a request is accepted at a rising edge where valid && ready.
- ready (feature off): high only in IDLE (and not in reset).
- States: IDLE, DRIVE, GAP.
- IDLE:
  - Legal accepted code -> DRIVE. Next cycle: sel = 1<<code, counter loaded with HOLD_CYCLES-1.
  - Illegal accepted code (VALID_MASK[code]==0) -> stay IDLE, sel stays 0, err=1 for exactly the next cycle.
- DRIVE:
  - sel holds its value and the counter decrements each cycle.
  - When counter==0 at an edge -> GAP.
  - sel is high for exactly HOLD_CYCLES cycles.
- GAP:
  - Lasts exactly 1 cycle, with sel=0 and done=1.
  - Next state is IDLE, or DRIVE if the optional queue holds an entry.
- flush:
  - Sampled high in DRIVE -> GAP on the next edge, regardless of the counter; done still pulses.
  - Ignored in IDLE and GAP.
- Latency: accept edge to sel asserted = 1 cycle.
- Throughput (feature off): one request per HOLD_CYCLES+2 cycles.
- Invariants:
  - sel is always zero or exactly one-hot.
  - Never two bits high; never a cycle where one select line hands directly to another.
- valid is ignored when ready is low; code is not latched.
- busy = (state != IDLE).
- Counter width: 8 bits. No wrap-around is possible for legal HOLD_CYCLES.

Optional Feature:
- Macro: BUS_DEC_QUEUE_EN.
- Enabled: one-entry request queue.
  - ready = queue empty; the decoder can accept while in DRIVE or GAP.
  - A queued request is stored with its code.
  - On leaving GAP with the queue occupied:
    - Legal code -> DRIVE directly, skipping IDLE.
    - Illegal code -> IDLE with err pulse.
  - The queue is cleared on dequeue.
  - Throughput: one drive per HOLD_CYCLES+1 cycles; the GAP cycle is always kept.
  - flush does not clear the queue.
  - clr empties the queue.
- Disabled: no queue storage. ready = IDLE only, and requests in other states are never accepted.

Test Plan:
- Reset mid-drive:
  - Stimulus: HOLD_CYCLES=3, accept code 5, assert clr in the second DRIVE cycle, between clock edges.
  - Response: sel=0 and busy=0 immediately without an edge; no done pulse; ready=1 after clr is released.
- Basic drive:
  - Stimulus: HOLD_CYCLES=1, accept code 5'd4.
  - Response: next cycle sel=32'h0000_0010, busy=1; following cycle sel=0, done=1; then ready=1.
- Hold length and extremes:
  - Stimulus: HOLD_CYCLES=4, codes 0 and 26.
  - Response: sel=32'h1 for exactly 4 cycles, then 1 GAP; same for sel=32'h0400_0000.
- Illegal codes:
  - Stimulus: accept code 24, then code 31.
  - Response: sel stays 0; err=1 for one cycle each; busy stays 0; done never pulses.
- Flush:
  - Stimulus: HOLD_CYCLES=8, accept code 7, pulse flush in the 2nd DRIVE cycle.
  - Response: sel=32'h80 for 2 cycles, then GAP with done=1, then IDLE.
- Back-to-back:
  - Stimulus: HOLD_CYCLES=2, hold valid continuously with code 3 then code 9.
  - Response, feature off: the second request is accepted only in IDLE. Sequence: sel=0x8 x2, 0, (IDLE), sel=0x200 x2.
  - Response, BUS_DEC_QUEUE_EN: sequence 0x8 x2, 0, 0x200 x2, 0; ready=0 while the queue is full.
